mem_arbiter: RTL and testbench

- Shares one single-port simulation RAM (word-indexed, 64-bit, combinational read, write at clock edge) between the instruction-fetch (IF) and load/store (LS) requesters.
- Performs address translation (address minus BASE, then shifted right by 3) and range/alignment checks.
- Builds byte-lane write masks, and extracts and sign-extends load data.
- Exactly one transaction is outstanding at a time. Responses are registered and handshaked.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side bundle of the IF/LS memory arbiter.
// The slave modport is the arbiter; the master modport is the requester/RAM side.
interface mem_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic        if_resp_ready;
  logic [31:0] if_resp_inst;
  logic        if_resp_err;

  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [63:0] ls_req_addr;
  logic        ls_req_wen;
  logic [1:0]  ls_req_size;
  logic        ls_req_signed;
  logic [63:0] ls_req_wdata;
  logic        ls_resp_valid;
  logic        ls_resp_ready;
  logic [63:0] ls_resp_rdata;
  logic        ls_resp_err;

  logic        ram_en;
  logic [63:0] ram_idx;
  logic [63:0] ram_rdata;
  logic        ram_wen;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;

  modport slave (
    input  if_req_valid, if_req_addr, if_resp_ready,
    input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_size, ls_req_signed,
    input  ls_req_wdata, ls_resp_ready, ram_rdata,
    output if_req_ready, if_resp_valid, if_resp_inst, if_resp_err,
    output ls_req_ready, ls_resp_valid, ls_resp_rdata, ls_resp_err,
    output ram_en, ram_idx, ram_wen, ram_wdata, ram_wmask
  );

  modport master (
    output if_req_valid, if_req_addr, if_resp_ready,
    output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_size, ls_req_signed,
    output ls_req_wdata, ls_resp_ready, ram_rdata,
    input  if_req_ready, if_resp_valid, if_resp_inst, if_resp_err,
    input  ls_req_ready, ls_resp_valid, ls_resp_rdata, ls_resp_err,
    input  ram_en, ram_idx, ram_wen, ram_wdata, ram_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and load/store,
// one transaction in flight, with address checks, byte-lane stores and load extension.
module mem_arbiter #(
  parameter logic [63:0] BASE          = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_BYTES     = 64'h0000_0000_0800_0000,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  typedef enum logic [1:0] {IDLE, IF_RESP, LS_RESP} state_t;

  state_t        state;
  logic [SW-1:0] ls_streak;

  // Subtract-then-compare keeps the upper bound free of wrap-around.
  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < MEM_BYTES);
  endfunction

  function automatic logic ls_misaligned(input logic [2:0] a, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return |a[2:0];
    endcase
  endfunction

  function automatic logic [63:0] byte_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0]  lanes;
    logic [63:0] m;
    case (size)
      2'd0:    lanes = 8'h01;
      2'd1:    lanes = 8'h03;
      2'd2:    lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase
    lanes = lanes << lane;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{lanes[i]}};
    return m;
  endfunction

  function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [1:0] size,
                                              input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic signed [63:0] ext;
    b = raw[7:0];
    h = raw[15:0];
    w = raw[31:0];
    case (size)
      2'd0:    if (sgn) ext = b; else ext = $signed({56'b0, raw[7:0]});
      2'd1:    if (sgn) ext = h; else ext = $signed({48'b0, raw[15:0]});
      2'd2:    if (sgn) ext = w; else ext = $signed({32'b0, raw[31:0]});
      default: ext = $signed(raw);
    endcase
    return $unsigned(ext);
  endfunction

  logic        idle_p0, grant_if_p0, grant_ls_p0, grant_p0;
  logic        err_if_p0, err_ls_p0, err_p0, store_p0;
  logic [63:0] addr_p0, off_p0, load_p0;
  logic [2:0]  lane_p0;
  logic [31:0] inst_p0;

  // Stage p0: arbitration, checks and RAM access within the grant cycle.
  assign idle_p0     = (state == IDLE) && !rst;
  assign grant_ls_p0 = idle_p0 && bus.ls_req_valid &&
                       !(bus.if_req_valid && (ls_streak >= STREAK_MAX));
  assign grant_if_p0 = idle_p0 && bus.if_req_valid && !grant_ls_p0;
  assign grant_p0    = grant_if_p0 || grant_ls_p0;

  assign addr_p0   = grant_ls_p0 ? bus.ls_req_addr : bus.if_req_addr;
  assign off_p0    = addr_p0 - BASE;
  assign lane_p0   = addr_p0[2:0];
  assign err_if_p0 = !in_range(bus.if_req_addr) || (|bus.if_req_addr[1:0]);
  assign err_ls_p0 = !in_range(bus.ls_req_addr) ||
                     ls_misaligned(bus.ls_req_addr[2:0], bus.ls_req_size);
  assign err_p0    = grant_ls_p0 ? err_ls_p0 : err_if_p0;
  assign store_p0  = grant_ls_p0 && bus.ls_req_wen && !err_ls_p0;

  assign bus.if_req_ready = grant_if_p0;
  assign bus.ls_req_ready = grant_ls_p0;
  assign bus.ram_en       = grant_p0 && !err_p0;
  assign bus.ram_idx      = grant_p0 ? (off_p0 >> 3) : '0;
  assign bus.ram_wen      = store_p0;
  assign bus.ram_wdata    = store_p0 ? (bus.ls_req_wdata << {lane_p0, 3'b000}) : '0;
  assign bus.ram_wmask    = store_p0 ? byte_mask(bus.ls_req_size, lane_p0) : '0;

  assign load_p0 = extend_load(bus.ram_rdata >> {lane_p0, 3'b000}, bus.ls_req_size,
                               bus.ls_req_signed);
  assign inst_p0 = lane_p0[2] ? bus.ram_rdata[63:32] : bus.ram_rdata[31:0];

  // Stage p1: registered responses held until the requester takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      ls_streak         <= '0;
      bus.if_resp_valid <= 1'b0;
      bus.if_resp_inst  <= '0;
      bus.if_resp_err   <= 1'b0;
      bus.ls_resp_valid <= 1'b0;
      bus.ls_resp_rdata <= '0;
      bus.ls_resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ls_p0) begin
            state             <= LS_RESP;
            bus.ls_resp_valid <= 1'b1;
            bus.ls_resp_err   <= err_ls_p0;
            bus.ls_resp_rdata <= (err_ls_p0 || bus.ls_req_wen) ? '0 : load_p0;
            if (bus.if_req_valid)
              ls_streak <= (ls_streak >= STREAK_MAX) ? STREAK_MAX : ls_streak + 1'b1;
            else
              ls_streak <= '0;
          end else if (grant_if_p0) begin
            state             <= IF_RESP;
            bus.if_resp_valid <= 1'b1;
            bus.if_resp_err   <= err_if_p0;
            bus.if_resp_inst  <= err_if_p0 ? '0 : inst_p0;
            ls_streak         <= '0;
          end
        end
        IF_RESP: begin
          if (bus.if_resp_ready) begin
            state             <= IDLE;
            bus.if_resp_valid <= 1'b0;
          end
        end
        LS_RESP: begin
          if (bus.ls_resp_ready) begin
            state             <= IDLE;
            bus.ls_resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte-level memory/arbitration model checked
// every cycle, plus literal expectations for the hand-worked scenarios.
module tb_mem_arbiter;
  localparam logic [63:0] BASE      = 64'h0000_0000_8000_0000;
  localparam logic [63:0] MEM_BYTES = 64'h0000_0000_0800_0000;
  localparam int          MAXS      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  mem_arbiter_if bus ();

  mem_arbiter #(.BASE(BASE), .MEM_BYTES(MEM_BYTES), .MAX_LS_STREAK(MAXS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Simulation RAM: 64 words, anything beyond reads as zero and ignores writes.
  logic [63:0] ram [64] = '{default: '0};
  always_comb bus.ram_rdata = (bus.ram_idx < 64) ? ram[bus.ram_idx[5:0]] : '0;
  always @(posedge clk)
    if (bus.ram_wen && bus.ram_idx < 64)
      ram[bus.ram_idx[5:0]] <= (ram[bus.ram_idx[5:0]] & ~bus.ram_wmask) |
                               (bus.ram_wdata & bus.ram_wmask);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  sh [logic [63:0]];
  int          busy = 0;       // 0 idle, 1 fetch response owed, 2 LS response owed
  int          streak_m = 0;
  logic [31:0] exp_inst;
  logic        exp_if_err;
  logic [63:0] exp_rdata;
  logic        exp_ls_err;
  byte         glog[$];
  int          gcyc[$];

  function automatic logic [7:0] shb(input logic [63:0] a);
    return sh.exists(a) ? sh[a] : 8'h00;
  endfunction

  function automatic logic out_of_range(input logic [63:0] a);
    return (a < BASE) || ((a - BASE) >= MEM_BYTES);
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input int size,
                                             input logic sgn);
    int          n;
    logic [63:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(shb(a + 64'(i))) << (8 * i));
    if (sgn && size < 3 && v[8*n-1])
      for (int i = n; i < 8; i++) v = v | (64'hFF << (8 * i));
    return v;
  endfunction

  always @(negedge clk) begin : cmp
    logic        if_v, ls_v, e_if, e_ls, err, st;
    logic [63:0] a, m, w;
    int          n, o, sz;
    if (rst) begin
      chk("rst_ram_wen", 64'(bus.ram_wen), 64'd0);
      busy = 0;
      streak_m = 0;
    end else begin
      if_v = bus.if_req_valid;
      ls_v = bus.ls_req_valid;
      e_ls = (busy == 0) && ls_v && !(if_v && streak_m >= MAXS);
      e_if = (busy == 0) && if_v && !e_ls;
      chk("if_req_ready", 64'(bus.if_req_ready), 64'(e_if));
      chk("ls_req_ready", 64'(bus.ls_req_ready), 64'(e_ls));
      chk("if_resp_valid", 64'(bus.if_resp_valid), 64'(busy == 1));
      chk("ls_resp_valid", 64'(bus.ls_resp_valid), 64'(busy == 2));
      if (busy == 1) begin
        chk("if_resp_inst", 64'(bus.if_resp_inst), 64'(exp_inst));
        chk("if_resp_err", 64'(bus.if_resp_err), 64'(exp_if_err));
      end
      if (busy == 2) begin
        chk("ls_resp_rdata", bus.ls_resp_rdata, exp_rdata);
        chk("ls_resp_err", 64'(bus.ls_resp_err), 64'(exp_ls_err));
      end
      a   = e_ls ? bus.ls_req_addr : bus.if_req_addr;
      sz  = int'(bus.ls_req_size);
      n   = 1 << sz;
      err = e_ls ? (out_of_range(a) || (a % 64'(n)) != 0)
                 : (out_of_range(a) || a[1:0] != 2'b00);
      st  = e_ls && bus.ls_req_wen && !err;
      chk("ram_wen", 64'(bus.ram_wen), 64'(st));
      if (e_ls || e_if) begin
        chk("ram_en", 64'(bus.ram_en), 64'(!err));
        if (!err) chk("ram_idx", bus.ram_idx, (a - BASE) / 8);
      end
      m = '0;
      w = '0;
      if (st) begin
        o = int'(a[2:0]);
        for (int i = 0; i < n; i++) begin
          m[8*(o+i) +: 8] = 8'hFF;
          w[8*(o+i) +: 8] = bus.ls_req_wdata[8*i +: 8];
        end
      end
      chk("ram_wmask", bus.ram_wmask, m);
      chk("ram_wdata", bus.ram_wdata, w);
      if (bus.ls_req_ready && ls_v) begin glog.push_back("L"); gcyc.push_back(cycle); end
      if (bus.if_req_ready && if_v) begin glog.push_back("I"); gcyc.push_back(cycle); end
      if (busy == 1 && bus.if_resp_ready) busy = 0;
      if (busy == 2 && bus.ls_resp_ready) busy = 0;
      if (e_ls) begin
        busy       = 2;
        exp_ls_err = err;
        exp_rdata  = (err || bus.ls_req_wen) ? '0 : model_load(a, sz, bus.ls_req_signed);
        if (st) for (int i = 0; i < n; i++) sh[a + 64'(i)] = bus.ls_req_wdata[8*i +: 8];
        streak_m   = if_v ? ((streak_m + 1 > MAXS) ? MAXS : streak_m + 1) : 0;
      end else if (e_if) begin
        busy       = 1;
        exp_if_err = err;
        exp_inst   = err ? '0 : model_load(a, 2, 1'b0)[31:0];
        streak_m   = 0;
      end
    end
  end

  // ---------------- directed drivers ----------------
  task automatic ls_txn(input logic [63:0] a, input logic wen, input logic [1:0] sz,
                        input logic sg, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output logic [63:0] idx,
                        output logic [63:0] mk, output logic [63:0] wdo);
    bit got = 0;
    rd = '0; er = 1'b0; idx = '0; mk = '0; wdo = '0;
    bus.ls_req_addr = a; bus.ls_req_wen = wen; bus.ls_req_size = sz;
    bus.ls_req_signed = sg; bus.ls_req_wdata = wd; bus.ls_req_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.ls_req_ready) begin
        got = 1; idx = bus.ram_idx; mk = bus.ram_wmask; wdo = bus.ram_wdata;
      end
    end
    if (!got) timeout("ls_grant");
    @(posedge clk); #1 bus.ls_req_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.ls_resp_valid && bus.ls_resp_ready) begin
        got = 1; rd = bus.ls_resp_rdata; er = bus.ls_resp_err;
      end
    end
    if (!got) timeout("ls_resp");
    @(posedge clk); #1;
  endtask

  task automatic if_txn(input logic [63:0] a, output logic [31:0] inst, output logic er,
                        output logic [63:0] idx);
    bit got = 0;
    inst = '0; er = 1'b0; idx = '0;
    bus.if_req_addr = a; bus.if_req_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.if_req_ready) begin got = 1; idx = bus.ram_idx; end
    end
    if (!got) timeout("if_grant");
    @(posedge clk); #1 bus.if_req_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.if_resp_valid && bus.if_resp_ready) begin
        got = 1; inst = bus.if_resp_inst; er = bus.if_resp_err;
      end
    end
    if (!got) timeout("if_resp");
    @(posedge clk); #1;
  endtask

  task automatic wait_log(input int want, input string name);
    for (int k = 0; k < 60 && glog.size() < want; k++) @(posedge clk);
    if (glog.size() < want) timeout(name);
  endtask

  initial begin
    logic [63:0] rd, idx, mk, wdo;
    logic [31:0] inst;
    logic        er;
    bus.if_req_valid = 0; bus.if_req_addr = '0; bus.if_resp_ready = 1;
    bus.ls_req_valid = 0; bus.ls_req_addr = '0; bus.ls_req_wen = 0; bus.ls_req_size = '0;
    bus.ls_req_signed = 0; bus.ls_req_wdata = '0; bus.ls_resp_ready = 1;

    @(negedge clk);
    chk("rst_if_valid", 64'(bus.if_resp_valid), 64'd0);
    chk("rst_ls_valid", 64'(bus.ls_resp_valid), 64'd0);
    chk("rst_ls_rdata", bus.ls_resp_rdata, 64'd0);
    chk("rst_if_inst", 64'(bus.if_resp_inst), 64'd0);
    chk("rst_ram_en", 64'(bus.ram_en), 64'd0);
    chk("rst_wmask", bus.ram_wmask, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Fill word 0, then fetch both halves.
    ls_txn(BASE, 1, 2'd3, 0, 64'h1111_2222_3333_4444, rd, er, idx, mk, wdo);
    chk("st_dw_mask", mk, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("st_dw_rdata", rd, 64'd0);
    if_txn(BASE + 4, inst, er, idx);
    chk("if_hi_inst", 64'(inst), 64'h1111_2222);
    chk("if_hi_err", 64'(er), 64'd0);
    chk("if_hi_idx", idx, 64'd0);
    if_txn(BASE, inst, er, idx);
    chk("if_lo_inst", 64'(inst), 64'h3333_4444);

    // Half store into word 1 and signed/unsigned reload.
    ls_txn(BASE + 64'hA, 1, 2'd1, 0, 64'hBEEF, rd, er, idx, mk, wdo);
    chk("st_h_idx", idx, 64'd1);
    chk("st_h_mask", mk, 64'h0000_0000_FFFF_0000);
    chk("st_h_wdata", wdo, 64'h0000_0000_BEEF_0000);
    ls_txn(BASE + 64'hA, 0, 2'd1, 1, '0, rd, er, idx, mk, wdo);
    chk("ld_h_s", rd, 64'hFFFF_FFFF_FFFF_BEEF);
    ls_txn(BASE + 64'hA, 0, 2'd1, 0, '0, rd, er, idx, mk, wdo);
    chk("ld_h_u", rd, 64'h0000_0000_0000_BEEF);

    // Word 2 lanes: byte/word extraction.
    ls_txn(BASE + 64'h10, 1, 2'd3, 0, 64'h8877_6655_4433_2211, rd, er, idx, mk, wdo);
    ls_txn(BASE + 64'h17, 0, 2'd0, 1, '0, rd, er, idx, mk, wdo);
    chk("ld_b_s", rd, 64'hFFFF_FFFF_FFFF_FF88);
    ls_txn(BASE + 64'h14, 0, 2'd2, 0, '0, rd, er, idx, mk, wdo);
    chk("ld_w_u", rd, 64'h0000_0000_8877_6655);
    ls_txn(BASE + 64'h10, 0, 2'd2, 1, '0, rd, er, idx, mk, wdo);
    chk("ld_w_s_pos", rd, 64'h0000_0000_4433_2211);
    ls_txn(BASE + 64'h13, 1, 2'd0, 0, 64'hAB, rd, er, idx, mk, wdo);
    chk("st_b_mask", mk, 64'h0000_0000_FF00_0000);
    chk("st_b_wdata", wdo, 64'h0000_0000_AB00_0000);
    ls_txn(BASE + 64'h10, 0, 2'd3, 0, '0, rd, er, idx, mk, wdo);
    chk("ld_dw", rd, 64'h8877_6655_AB33_2211);

    // Errors: misaligned, below base, at top, and the last valid word.
    ls_txn(BASE + 2, 0, 2'd2, 1, '0, rd, er, idx, mk, wdo);
    chk("mis_w_err", 64'(er), 64'd1);
    chk("mis_w_rdata", rd, 64'd0);
    if_txn(64'h7FFF_FFFC, inst, er, idx);
    chk("if_low_err", 64'(er), 64'd1);
    chk("if_low_inst", 64'(inst), 64'd0);
    if_txn(BASE + 2, inst, er, idx);
    chk("if_mis_err", 64'(er), 64'd1);
    ls_txn(BASE + MEM_BYTES, 1, 2'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, idx, mk, wdo);
    chk("st_top_err", 64'(er), 64'd1);
    ls_txn(BASE + 1, 1, 2'd1, 0, 64'h1234, rd, er, idx, mk, wdo);
    chk("st_mis_err", 64'(er), 64'd1);
    ls_txn(BASE + MEM_BYTES - 8, 0, 2'd3, 0, '0, rd, er, idx, mk, wdo);
    chk("ld_last_err", 64'(er), 64'd0);
    chk("ld_last_idx", idx, 64'h0000_0000_00FF_FFFF);

    // Both requesters valid continuously.
    glog.delete(); gcyc.delete();
    bus.ls_req_addr = BASE; bus.ls_req_wen = 0; bus.ls_req_size = 2'd3;
    bus.if_req_addr = BASE;
    bus.ls_req_valid = 1; bus.if_req_valid = 1;
    wait_log(6, "streak_log");
    #1 bus.ls_req_valid = 0; bus.if_req_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    if (glog.size() >= 6)
      chk("streak_order", {glog[0], glog[1], glog[2], glog[3], glog[4], glog[5]}, "LLLLIL");

    // Response held back for five cycles while a fetch waits.
    glog.delete(); gcyc.delete();
    bus.ls_resp_ready = 0; bus.ls_req_addr = BASE + 64'h10; bus.ls_req_valid = 1;
    wait_log(1, "hold_grant");
    #1 bus.ls_req_valid = 0; bus.if_req_valid = 1; bus.if_req_addr = BASE;
    @(negedge clk);
    chk("hold_rdata", bus.ls_resp_rdata, 64'h8877_6655_AB33_2211);
    chk("hold_if_ready", 64'(bus.if_req_ready), 64'd0);
    repeat (5) @(posedge clk);
    #1 bus.ls_resp_ready = 1;
    wait_log(2, "hold_if_grant");
    #1 bus.if_req_valid = 0;
    if (glog.size() >= 2) begin
      chk("hold_order", {glog[0], glog[1]}, "LI");
      chk("hold_if_gap", 64'(gcyc[1] - gcyc[0]), 64'd7);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset during LS_RESP with a streak of three built up.
    glog.delete(); gcyc.delete();
    bus.ls_req_addr = BASE; bus.ls_req_valid = 1; bus.if_req_valid = 1;
    wait_log(3, "rst_pre");
    #1 bus.ls_resp_ready = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; bus.ls_resp_ready = 1;
    glog.delete(); gcyc.delete();
    @(negedge clk);
    chk("rst_ls_resp_gone", 64'(bus.ls_resp_valid), 64'd0);
    wait_log(5, "rst_post");
    #1 bus.ls_req_valid = 0; bus.if_req_valid = 0;
    if (glog.size() >= 5)
      chk("rst_streak_order", {glog[0], glog[1], glog[2], glog[3], glog[4]}, "LLLLI");
    repeat (3) @(posedge clk);
    #1 rst = 1; bus.if_req_valid = 1; bus.if_req_addr = BASE;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_if_immediate", 64'(bus.if_req_ready), 64'd1);
    @(posedge clk); #1 bus.if_req_valid = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end
endmodule
